// File: rtl/tlul_pkg.sv
// TL-UL field widths, opcodes and packed host/device channel payloads.
package tlul_pkg;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned DBW = DW / 8;
  localparam int unsigned AIW = 8;
  localparam int unsigned SZW = 2;
  localparam int unsigned DUW = 16;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // h2d: a_valid[101] ... d_ready[0]
  typedef struct packed {
    logic           a_valid;
    logic [2:0]     a_opcode;
    logic [2:0]     a_param;
    logic [SZW-1:0] a_size;
    logic [AIW-1:0] a_source;
    logic [AW-1:0]  a_address;
    logic [DBW-1:0] a_mask;
    logic [DW-1:0]  a_data;
    logic [DUW-1:0] a_user;
    logic           d_ready;
  } tl_h2d_t;

  // d2h: d_valid[67] ... a_ready[0]
  typedef struct packed {
    logic           d_valid;
    logic [2:0]     d_opcode;
    logic [2:0]     d_param;
    logic [SZW-1:0] d_size;
    logic [AIW-1:0] d_source;
    logic           d_sink;
    logic [DW-1:0]  d_data;
    logic [DUW-1:0] d_user;
    logic           d_error;
    logic           a_ready;
  } tl_d2h_t;

  // Full-word writes use PutFullData, any partial mask needs PutPartialData.
  function automatic logic [2:0] a_opcode_for(logic we, logic [DBW-1:0] be);
    if (!we)                   return 3'(Get);
    else if (be == {DBW{1'b1}}) return 3'(PutFullData);
    else                       return 3'(PutPartialData);
  endfunction

endpackage

// File: rtl/tlul_host_adapter.sv
// TL-UL initiator: converts a req/gnt/rvalid register port into A-channel requests and
// retires out-of-order D-channel responses through a slot table indexed by a_source.
module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned MaxReqs = 2,
  parameter logic [7:0]  SrcBase = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DW-1:0]         wdata_i,
  input  logic [DBW-1:0]        be_i,
  output logic                  rvalid_o,
  output logic [DW-1:0]         rdata_o,
  output logic                  err_o,
  output logic                  spurious_o,
  output logic [4:0]            outstanding_o,
  output tl_h2d_t               tl_o,
  input  tl_d2h_t               tl_i
);

  localparam int unsigned IdW = (MaxReqs > 1) ? $clog2(MaxReqs) : 1;
  localparam logic [IdW-1:0] LastSlot = IdW'(MaxReqs - 1);

  logic [MaxReqs-1:0] busy_q, busy_d;
  logic [MaxReqs-1:0] is_read_q, is_read_d;
  logic [IdW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;
  logic               spurious_q, spurious_d;
  logic [DW-1:0]      rdata_q, rdata_d;

  logic               a_valid;
  logic [IdW-1:0]     d_slot;
  logic               d_hit;
  logic               d_read;
  logic               d_err;

  // A channel: stall whenever the next slot in allocation order is still busy
  always_comb begin
    a_valid = req_i & ~busy_q[wr_ptr_q];
    gnt_o   = a_valid & tl_i.a_ready;
  end

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_opcode  = a_opcode_for(we_i, be_i);
    tl_o.a_size    = SZW'(2);
    tl_o.a_source  = {SrcBase[AIW-1:IdW], wr_ptr_q};
    tl_o.a_address = {addr_i[AW-1:2], 2'b00};
    tl_o.a_mask    = we_i ? be_i : {DBW{1'b1}};
    tl_o.a_data    = we_i ? wdata_i : '0;
    tl_o.d_ready   = 1'b1;
  end

  // D channel: a beat only retires a slot that carries our upper source bits and is busy
  always_comb begin
    d_slot = tl_i.d_source[IdW-1:0];
    d_hit  = tl_i.d_valid
           & (tl_i.d_source[AIW-1:IdW] == SrcBase[AIW-1:IdW])
           & (32'(d_slot) < MaxReqs)
           & busy_q[d_slot];
    d_read = is_read_q[d_slot];
    d_err  = tl_i.d_error
           | (tl_i.d_opcode != (d_read ? 3'(AccessAckData) : 3'(AccessAck)));
  end

  // Next-state: accept and retire never target the same slot (one needs it free, the other busy)
  always_comb begin
    busy_d     = busy_q;
    is_read_d  = is_read_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;
    spurious_d = 1'b0;
    rdata_d    = '0;

    if (gnt_o) begin
      busy_d[wr_ptr_q]    = 1'b1;
      is_read_d[wr_ptr_q] = ~we_i;
      wr_ptr_d            = (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + IdW'(1);
    end

    if (d_hit) begin
      busy_d[d_slot] = 1'b0;
      rvalid_d       = 1'b1;
      err_d          = d_err;
      rdata_d        = (d_read && !d_err) ? tl_i.d_data : '0;
    end else if (tl_i.d_valid) begin
      spurious_d = 1'b1;
    end

    case ({gnt_o, d_hit})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      is_read_q  <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      spurious_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      busy_q     <= busy_d;
      is_read_q  <= is_read_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      spurious_q <= spurious_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rvalid_o      = rvalid_q;
  assign err_o         = err_q;
  assign spurious_o    = spurious_q;
  assign rdata_o       = rdata_q;
  assign outstanding_o = cnt_q;

  logic unused_inputs;
  assign unused_inputs = ^{addr_i[1:0], tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed bench for tlul_host_adapter with a transaction-level model of outstanding sources.
module tb_tlul_host_adapter;
  import tlul_pkg::*;

  localparam int MAXR = 2;
  localparam logic [7:0] SRCB = 8'h00;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o, rvalid_o, err_o, spurious_o;
  logic [31:0] rdata_o;
  logic [4:0]  outstanding_o;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  int total = 0;
  int bad   = 0;

  // Model: set of outstanding sources (value = is_read), allocation index, expected response
  bit          m_out [int];
  int          m_ptr = 0;
  bit          e_rvalid = 0, e_spur = 0, e_err = 0;
  logic [31:0] e_rdata = '0;

  tlul_host_adapter #(.MaxReqs(MAXR), .SrcBase(SRCB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .spurious_o(spurious_o),
    .outstanding_o(outstanding_o), .tl_o(tl_o), .tl_i(tl_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int src_of(int slot);
    return (int'(SRCB) & ~(MAXR - 1)) + slot;
  endfunction

  // Compare at the falling edge, then advance the model with inputs the DUT sees next rise
  initial forever begin
    @(negedge clk_i);
    if (!rst_ni) begin
      m_out.delete();
      m_ptr = 0; e_rvalid = 0; e_spur = 0; e_err = 0; e_rdata = '0;
    end else begin
      bit          avail, take_a, rd;
      int          s;
      logic [2:0]  exp_op;
      avail  = !m_out.exists(src_of(m_ptr));
      take_a = req_i && tl_i.a_ready && avail;
      chk("m_gnt", 32'(gnt_o), 32'(take_a));
      chk("m_a_valid", 32'(tl_o.a_valid), 32'(req_i && avail));
      chk("m_d_ready", 32'(tl_o.d_ready), 32'd1);
      if (req_i && avail) begin
        exp_op = !we_i ? 3'd4 : (be_i == 4'hF ? 3'd0 : 3'd1);
        chk("m_opcode", 32'(tl_o.a_opcode), 32'(exp_op));
        chk("m_source", 32'(tl_o.a_source), 32'(src_of(m_ptr)));
        chk("m_address", tl_o.a_address, addr_i & 32'hFFFF_FFFC);
        chk("m_mask", 32'(tl_o.a_mask), we_i ? 32'(be_i) : 32'hF);
        chk("m_data", tl_o.a_data, we_i ? wdata_i : 32'd0);
        chk("m_size_param_user", {13'd0, tl_o.a_size, tl_o.a_param, tl_o.a_user},
            {13'd0, 2'd2, 3'd0, 16'd0});
      end
      chk("m_rvalid", 32'(rvalid_o), 32'(e_rvalid));
      chk("m_spurious", 32'(spurious_o), 32'(e_spur));
      chk("m_outstanding", 32'(outstanding_o), 32'(m_out.num()));
      if (e_rvalid) begin
        chk("m_err", 32'(err_o), 32'(e_err));
        chk("m_rdata", rdata_o, e_rdata);
      end
      e_rvalid = 0; e_spur = 0; e_err = 0; e_rdata = '0;
      if (tl_i.d_valid) begin
        s = int'(tl_i.d_source);
        if (m_out.exists(s)) begin
          rd       = m_out[s];
          e_rvalid = 1;
          e_err    = tl_i.d_error || (tl_i.d_opcode != (rd ? 3'd1 : 3'd0));
          e_rdata  = (rd && !e_err) ? tl_i.d_data : 32'd0;
          m_out.delete(s);
        end else begin
          e_spur = 1;
        end
      end
      if (take_a) begin
        m_out[src_of(m_ptr)] = !we_i;
        m_ptr = (m_ptr + 1) % MAXR;
      end
    end
  end

  task automatic set_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; be_i = be;
  endtask

  task automatic wait_gnt(output logic [7:0] src);
    bit got = 0;
    src = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (gnt_o) begin
        got = 1;
        src = tl_o.a_source;
        break;
      end
    end
    @(posedge clk_i); #1;
    req_i = 1'b0;
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic d_beat(input logic [7:0] src, input logic [2:0] op, input logic [31:0] data,
                        input logic err);
    tl_i.d_valid = 1'b1; tl_i.d_source = src; tl_i.d_opcode = op;
    tl_i.d_data = data; tl_i.d_error = err;
    @(posedge clk_i); #1;
    tl_i.d_valid = 1'b0; tl_i.d_source = '0; tl_i.d_opcode = '0;
    tl_i.d_data = '0; tl_i.d_error = 1'b0;
  endtask

  initial begin
    logic [7:0] s0, s1, s2;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    tl_i = '0; tl_i.a_ready = 1'b1;
    repeat (2) @(posedge clk_i); #1;
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_spurious", 32'(spurious_o), 32'd0);
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_a_valid", 32'(tl_o.a_valid), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // 1: full write
    set_req(1'b1, 32'h100, 32'hDEADBEEF, 4'hF); #1;
    chk("t1_opcode", 32'(tl_o.a_opcode), 32'd0);
    chk("t1_mask", 32'(tl_o.a_mask), 32'hF);
    chk("t1_source", 32'(tl_o.a_source), 32'd0);
    chk("t1_data", tl_o.a_data, 32'hDEADBEEF);
    wait_gnt(s0);
    d_beat(s0, 3'd0, 32'hAAAA_AAAA, 1'b0);
    chk("t1_rvalid", 32'(rvalid_o), 32'd1);
    chk("t1_err", 32'(err_o), 32'd0);
    chk("t1_rdata", rdata_o, 32'd0);

    // 2: read with unaligned address, A held off by a_ready first
    set_req(1'b0, 32'h107, 32'h0, 4'h0); tl_i.a_ready = 1'b0; #1;
    chk("t2_gnt_noready", 32'(gnt_o), 32'd0);
    chk("t2_address", tl_o.a_address, 32'h104);
    chk("t2_opcode", 32'(tl_o.a_opcode), 32'd4);
    @(posedge clk_i); #1;
    tl_i.a_ready = 1'b1;
    wait_gnt(s0);
    d_beat(s0, 3'd1, 32'h1234, 1'b0);
    chk("t2_rvalid", 32'(rvalid_o), 32'd1);
    chk("t2_rdata", rdata_o, 32'h1234);
    chk("t2_err", 32'(err_o), 32'd0);

    // 3: table full, out-of-order retire, third request waits for slot 0
    set_req(1'b0, 32'h200, 32'h0, 4'h0); wait_gnt(s0);
    set_req(1'b0, 32'h204, 32'h0, 4'h0); wait_gnt(s1);
    chk("t3_src_order", {16'd0, s0, s1}, 32'h0001);
    set_req(1'b0, 32'h208, 32'h0, 4'h0);
    repeat (3) begin
      @(negedge clk_i);
      chk("t3_stall_gnt", 32'(gnt_o), 32'd0);
    end
    chk("t3_outstanding", 32'(outstanding_o), 32'd2);
    @(posedge clk_i); #1;
    d_beat(8'd1, 3'd1, 32'h11, 1'b0);
    chk("t3_rdata_s1", rdata_o, 32'h11);
    chk("t3_out_after_s1", 32'(outstanding_o), 32'd1);
    chk("t3_gnt_ptr_busy", 32'(gnt_o), 32'd0);
    d_beat(8'd0, 3'd1, 32'h22, 1'b0);
    chk("t3_rdata_s0", rdata_o, 32'h22);
    chk("t3_gnt_after_free", 32'(gnt_o), 32'd1);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    chk("t3_out_third", 32'(outstanding_o), 32'd1);
    d_beat(8'd0, 3'd1, 32'h33, 1'b0);
    chk("t3_rdata_third", rdata_o, 32'h33);

    // 4: partial write answered with wrong opcode, then read with d_error
    set_req(1'b1, 32'h300, 32'hCAFEF00D, 4'b0011); #1;
    chk("t4_opcode", 32'(tl_o.a_opcode), 32'd1);
    chk("t4_mask", 32'(tl_o.a_mask), 32'h3);
    wait_gnt(s0);
    d_beat(s0, 3'd1, 32'h5555, 1'b0);
    chk("t4_err_opcode", 32'(err_o), 32'd1);
    chk("t4_rdata_opcode", rdata_o, 32'd0);
    set_req(1'b0, 32'h304, 32'h0, 4'h0); wait_gnt(s0);
    d_beat(s0, 3'd1, 32'h6666, 1'b1);
    chk("t4_err_derror", 32'(err_o), 32'd1);
    chk("t4_rdata_derror", rdata_o, 32'd0);

    // 5: spurious beats (idle source, and foreign upper source bits)
    d_beat(8'd1, 3'd0, 32'h0, 1'b0);
    chk("t5_spurious", 32'(spurious_o), 32'd1);
    chk("t5_no_rvalid", 32'(rvalid_o), 32'd0);
    @(posedge clk_i); #1;
    chk("t5_pulse_end", 32'(spurious_o), 32'd0);
    set_req(1'b0, 32'h500, 32'h0, 4'h0); wait_gnt(s0);
    d_beat(s0 | 8'h80, 3'd1, 32'h99, 1'b0);
    chk("t5_foreign_spurious", 32'(spurious_o), 32'd1);
    chk("t5_foreign_outstanding", 32'(outstanding_o), 32'd1);
    d_beat(s0, 3'd1, 32'h77, 1'b0);
    chk("t5_rdata", rdata_o, 32'h77);

    // 6: reset with two outstanding, leaving wr_ptr away from 0 beforehand
    set_req(1'b0, 32'h600, 32'h0, 4'h0); wait_gnt(s0);
    d_beat(s0, 3'd1, 32'h1, 1'b0);
    set_req(1'b0, 32'h604, 32'h0, 4'h0); wait_gnt(s1);
    set_req(1'b0, 32'h608, 32'h0, 4'h0); wait_gnt(s2);
    chk("t6_out_before", 32'(outstanding_o), 32'd2);
    #3 rst_ni = 1'b0;
    #1;
    chk("t6_out_reset", 32'(outstanding_o), 32'd0);
    chk("t6_rvalid_reset", 32'(rvalid_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    d_beat(s1, 3'd1, 32'h42, 1'b0);
    chk("t6_late_spurious", 32'(spurious_o), 32'd1);
    chk("t6_late_no_rvalid", 32'(rvalid_o), 32'd0);
    set_req(1'b0, 32'h700, 32'h0, 4'h0); #1;
    chk("t6_ptr_reset", 32'(tl_o.a_source), 32'd0);
    wait_gnt(s0);
    d_beat(s0, 3'd1, 32'hBEEF, 1'b0);
    chk("t6_rdata", rdata_o, 32'hBEEF);

    repeat (3) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
